// File: rtl/priority_request_scheduler_if.sv
// Handshake and status bundle between the request scheduler and its consumer.
// The consumer side uses master; the scheduler uses slave.
interface priority_request_scheduler_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNT_W = 8
);
   logic             ena;
   logic [WIDTH-1:0] req_in;
   logic             idx_ready;
   logic             idx_valid;
   logic [7:0]       idx_out;
   logic [WIDTH-1:0] pending;
   logic [CNT_W-1:0] coll_cnt;

   modport master (
      output ena, req_in, idx_ready,
      input  idx_valid, idx_out, pending, coll_cnt
   );

   modport slave (
      input  ena, req_in, idx_ready,
      output idx_valid, idx_out, pending, coll_cnt
   );
endinterface

// File: rtl/priority_request_scheduler.sv
// Sticky request collector: latches request pulses and issues the highest
// pending index through a valid/ready handshake, one index per cycle.
module priority_request_scheduler #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned CNT_W     = 8,
   parameter logic [7:0]  NONE_CODE = 8'hF0
) (
   input logic                          clk,
   input logic                          rst_n,
   priority_request_scheduler_if.slave  bus
);
   localparam int unsigned IDX_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {S_IDLE = 1'b0, S_OFFER = 1'b1} state_t;

   state_t           r_state;
   logic [7:0]       r_idx;
   logic [WIDTH-1:0] r_pending;
   logic [CNT_W-1:0] r_coll;

   state_t           w_state_nxt;
   logic [7:0]       w_idx_nxt;
   logic [WIDTH-1:0] w_pending_nxt;
   logic [CNT_W-1:0] w_coll_nxt;
   logic [IDX_W-1:0] w_sel;
   logic             w_pend_nz;
   logic             w_xfer;
   logic             w_load;
   logic             w_coll;
   logic [WIDTH-1:0] w_mask;

   // Highest set bit of the registered pending vector wins
   always_comb begin
      w_sel = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (r_pending[i]) w_sel = IDX_W'(i);
      end
   end

   assign w_pend_nz = |r_pending;
   assign w_xfer    = bus.ena & (r_state == S_OFFER) & bus.idx_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_load      = 1'b0;
      if (bus.ena) begin
         case (r_state)
            S_IDLE: begin
               if (w_pend_nz) begin
                  w_state_nxt = S_OFFER;
                  w_idx_nxt   = 8'(w_sel);
                  w_load      = 1'b1;
               end
            end
            S_OFFER: begin
               if (w_xfer) begin
                  if (w_pend_nz) begin
                     w_idx_nxt = 8'(w_sel);
                     w_load    = 1'b1;
                  end else begin
                     w_state_nxt = S_IDLE;
                     w_idx_nxt   = NONE_CODE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // A request landing on the bit being issued re-arms it rather than colliding
   always_comb begin
      w_mask        = w_load ? (WIDTH'(1) << w_sel) : '0;
      w_coll        = |(bus.req_in & r_pending & ~w_mask);
      w_pending_nxt = bus.ena ? ((r_pending & ~w_mask) | bus.req_in) : r_pending;
      w_coll_nxt    = (bus.ena && w_coll && (r_coll != CNT_MAX)) ? r_coll + CNT_W'(1) : r_coll;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_idx     <= NONE_CODE;
         r_pending <= '0;
         r_coll    <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_idx     <= w_idx_nxt;
         r_pending <= w_pending_nxt;
         r_coll    <= w_coll_nxt;
      end
   end

   assign bus.idx_valid = (r_state == S_OFFER) & bus.ena;
   assign bus.idx_out   = (r_state == S_OFFER) ? r_idx : NONE_CODE;
   assign bus.pending   = r_pending;
   assign bus.coll_cnt  = r_coll;
endmodule

// File: tb/tb_priority_request_scheduler.sv
// Scoreboard bench for priority_request_scheduler: directed scenarios followed
// by random traffic, checked against a behavioural model of the scheduler.
module tb_priority_request_scheduler;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   priority_request_scheduler_if #(.WIDTH(16), .CNT_W(8)) bus ();

   priority_request_scheduler #(.WIDTH(16), .CNT_W(8), .NONE_CODE(8'hF0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic        v;
      logic [7:0]  idx;
      logic [15:0] pend;
      logic [7:0]  cnt;
   } exp_t;

   exp_t exp_q[$];
   int   xq[$];
   int   n_cmp = 0;
   int   n_fail = 0;

   // Reference model state: pending set, current offer, collision count
   logic [15:0] m_pend = '0;
   bit          m_valid = 1'b0;
   int          m_idx = 240;
   int          m_cnt = 0;
   bit          m_known = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int highest(input logic [15:0] v);
      int h = -1;
      for (int i = 0; i < 16; i++) if (v[i]) h = i;
      return h;
   endfunction

   task automatic model_step(input bit rst, input bit en, input logic [15:0] req, input bit rdy);
      logic [15:0] mask;
      bit          xfer;
      int          s;
      if (!rst) begin
         m_pend = '0; m_valid = 1'b0; m_idx = 240; m_cnt = 0; m_known = 1'b1;
         return;
      end
      if (!en) return;
      xfer = m_valid && rdy;
      mask = '0;
      if (xfer) xq.push_back(m_idx);
      if (!m_valid || xfer) begin
         s = highest(m_pend);
         if (s >= 0) begin
            m_idx = s; m_valid = 1'b1; mask[s] = 1'b1;
         end else begin
            m_idx = 240; m_valid = 1'b0;
         end
      end
      if ((req & m_pend & ~mask) != 16'h0) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      m_pend = (m_pend & ~mask) | req;
   endtask

   // Drive one cycle of inputs at the falling edge and queue the expected post-edge view
   task automatic cycle(input bit rst, input bit en, input logic [15:0] req, input bit rdy);
      exp_t e;
      @(negedge clk);
      rst_n         = rst;
      bus.ena       = en;
      bus.req_in    = req;
      bus.idx_ready = rdy;
      model_step(rst, en, req, rdy);
      if (m_known) begin
         e.v    = m_valid && en;
         e.idx  = m_valid ? 8'(m_idx) : 8'hF0;
         e.pend = m_pend;
         e.cnt  = 8'(m_cnt);
         exp_q.push_back(e);
      end
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   // State monitor: compares the registered view after every edge
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("mon_valid", 32'(bus.idx_valid), 32'(e.v));
         chk("mon_idx", 32'(bus.idx_out), 32'(e.idx));
         chk("mon_pending", 32'(bus.pending), 32'(e.pend));
         chk("mon_coll", 32'(bus.coll_cnt), 32'(e.cnt));
      end
   end

   // Transfer monitor: each accepted index must match the model's issue order
   always @(negedge clk) begin
      int e;
      #1;
      if (rst_n && bus.idx_valid === 1'b1 && bus.idx_ready === 1'b1) begin
         if (xq.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL xfer_unexpected: got idx %0d expected no transfer at %0t", bus.idx_out, $time);
         end else begin
            e = xq.pop_front();
            chk("xfer_idx", 32'(bus.idx_out), 32'(e));
         end
      end
   end

   initial begin
      int ord[5];
      bus.ena = 1'b1;
      bus.req_in = 16'hFFFF;
      bus.idx_ready = 1'b0;
      ord = '{15, 10, 5, 0, 240};

      // Reset with all requests asserted
      cycle(0, 1, 16'hFFFF, 0);
      cycle(0, 1, 16'hFFFF, 0);
      settle();
      chk("rst_valid", 32'(bus.idx_valid), 32'd0);
      chk("rst_idx", 32'(bus.idx_out), 32'hF0);
      chk("rst_pending", 32'(bus.pending), 32'h0);
      chk("rst_coll", 32'(bus.coll_cnt), 32'h0);

      // Ordering
      cycle(1, 1, 16'h8421, 1);
      for (int k = 0; k < 5; k++) begin
         cycle(1, 1, 16'h0, 1);
         settle();
         chk("ord_idx", 32'(bus.idx_out), 32'(ord[k]));
         chk("ord_valid", 32'(bus.idx_valid), (k < 4) ? 32'd1 : 32'd0);
      end

      // Stall with late arrival of bit 12
      cycle(1, 1, 16'h0088, 0);
      for (int k = 0; k < 5; k++) begin
         cycle(1, 1, (k == 3) ? 16'h1000 : 16'h0, 0);
         settle();
         chk("stall_idx", 32'(bus.idx_out), 32'd7);
         chk("stall_pending", 32'(bus.pending), (k < 3) ? 32'h0008 : 32'h1008);
      end
      cycle(1, 1, 16'h0, 1); settle(); chk("late_idx0", 32'(bus.idx_out), 32'd12);
      cycle(1, 1, 16'h0, 1); settle(); chk("late_idx1", 32'(bus.idx_out), 32'd3);
      cycle(1, 1, 16'h0, 1); settle(); chk("late_idx2", 32'(bus.idx_out), 32'hF0);

      // Collision counter saturation
      cycle(1, 1, 16'h0004, 0);
      cycle(1, 1, 16'h0004, 0);
      settle();
      chk("coll_start", 32'(bus.coll_cnt), 32'd0);
      for (int k = 0; k < 300; k++) cycle(1, 1, 16'h0004, 0);
      settle();
      chk("coll_sat", 32'(bus.coll_cnt), 32'd255);
      cycle(1, 1, 16'h0, 1);
      cycle(1, 1, 16'h0, 1);
      cycle(1, 1, 16'h0, 1);
      settle();
      chk("coll_hold", 32'(bus.coll_cnt), 32'd255);
      chk("coll_drain", 32'(bus.idx_out), 32'hF0);

      // Same-cycle set and issue
      cycle(1, 1, 16'h0010, 1);
      cycle(1, 1, 16'h0010, 1);
      settle();
      chk("same_idx", 32'(bus.idx_out), 32'd4);
      chk("same_pending", 32'(bus.pending), 32'h0010);
      cycle(1, 1, 16'h0, 1); settle(); chk("same_idx2", 32'(bus.idx_out), 32'd4);
      cycle(1, 1, 16'h0, 1); settle(); chk("same_done", 32'(bus.idx_out), 32'hF0);

      // Enable freeze, then reset during an offer
      cycle(1, 1, 16'h0021, 0);
      cycle(1, 1, 16'h0, 0);
      settle();
      chk("ena_idx", 32'(bus.idx_out), 32'd5);
      cycle(1, 0, 16'h0040, 1);
      settle();
      chk("ena_valid_low", 32'(bus.idx_valid), 32'd0);
      chk("ena_pending", 32'(bus.pending), 32'h0001);
      cycle(1, 1, 16'h0, 0);
      settle();
      chk("ena_resume_v", 32'(bus.idx_valid), 32'd1);
      chk("ena_resume_i", 32'(bus.idx_out), 32'd5);
      cycle(0, 1, 16'hFFFF, 1);
      settle();
      chk("mid_rst_idx", 32'(bus.idx_out), 32'hF0);
      chk("mid_rst_pend", 32'(bus.pending), 32'h0);
      chk("mid_rst_coll", 32'(bus.coll_cnt), 32'h0);

      // Random traffic
      for (int k = 0; k < 3000; k++) begin
         cycle($urandom_range(0, 199) != 0, $urandom_range(0, 9) != 0,
               16'($urandom & $urandom & $urandom), $urandom_range(0, 9) < 6);
      end
      for (int k = 0; k < 40; k++) cycle(1, 1, 16'h0, 1);
      settle();
      chk("drain_idle", 32'(bus.idx_valid), 32'd0);
      chk("xfer_q_empty", 32'(xq.size()), 32'd0);
      chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
